sonar_echo_emu: RTL and testbench

- Behavioural responder for the ultrasonic ranger interface: the far end of the trigger/echo protocol driven by the sonar ranging block.
- Accepts a trigger pulse and returns an echo pulse whose width encodes a programmed distance in inches, at CYCLES_PER_INCH clocks per inch.
- Used as a synthesizable hardware-in-loop stand-in for the physical sensor on a PMOD loopback, and as the bench model for the sonar/tone chain.

---
 rtl/sonar_echo_emu.sv | 160 ++++++++++++++++
 tb/tb_sonar_echo_emu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sonar_echo_emu.sv
// ============================================================================
// sonar_echo_emu : ultrasonic ranger stand-in, answers a trigger with an echo
//                  pulse of width distance * CYCLES_PER_INCH clocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sonar_echo_emu #(
  parameter int unsigned CYCLES_PER_INCH   = 14700,
  parameter int unsigned TRIG_MIN_CYCLES   = 1000,
  parameter int unsigned ECHO_DELAY_CYCLES = 5000,
  parameter int unsigned HOLDOFF_CYCLES    = 100000,
  parameter int unsigned MIN_INCHES        = 6,
  parameter int unsigned MAX_INCHES        = 254
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig_in,
  input  logic [8:0] distance_in,
  output logic       echo_out,
  output logic       busy,
  output logic       trig_short,
  output logic [8:0] dist_latched
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TRIG    = 3'd1,
    DELAY   = 3'd2,
    ECHO    = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam logic [15:0] WIDTH_MAX  = 16'hFFFF;
  localparam logic [31:0] TRIG_MIN   = 32'(TRIG_MIN_CYCLES);
  localparam logic [31:0] DELAY_LAST = 32'(ECHO_DELAY_CYCLES) - 32'd1;
  localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES) - 32'd1;
  localparam logic [31:0] CPI        = 32'(CYCLES_PER_INCH);
  localparam logic [8:0]  MIN_D      = 9'(MIN_INCHES);
  localparam logic [8:0]  MAX_D      = 9'(MAX_INCHES);

  state_t      state;
  logic        trig_meta;
  logic        trig_s;
  logic        trig_q;
  logic        trig_rise;
  logic        trig_fall;
  logic [15:0] width_cnt;
  logic [31:0] delay_cnt;
  logic [31:0] echo_cnt;
  logic [31:0] echo_len;
  logic [31:0] hold_cnt;
  logic [8:0]  dist_clamped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_meta <= 1'b0;
      trig_s    <= 1'b0;
      trig_q    <= 1'b0;
    end else begin
      trig_meta <= trig_in;
      trig_s    <= trig_meta;
      trig_q    <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_q;
  assign trig_fall = ~trig_s & trig_q;

  always_comb begin
    dist_clamped = distance_in;
    if (distance_in < MIN_D) begin
      dist_clamped = MIN_D;
    end else if (distance_in > MAX_D) begin
      dist_clamped = MAX_D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      echo_out     <= 1'b0;
      busy         <= 1'b0;
      trig_short   <= 1'b0;
      dist_latched <= MIN_D;
      width_cnt    <= 16'd0;
      delay_cnt    <= 32'd0;
      echo_cnt     <= 32'd0;
      echo_len     <= 32'd0;
      hold_cnt     <= 32'd0;
    end else begin
      trig_short <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_rise) begin
            // The rise cycle itself is the first high cycle of the pulse.
            width_cnt <= 16'd1;
            busy      <= 1'b1;
            state     <= TRIG;
          end
        end

        TRIG: begin
          if (trig_fall) begin
            if ({16'd0, width_cnt} >= TRIG_MIN) begin
              dist_latched <= dist_clamped;
              echo_len     <= {23'd0, dist_clamped} * CPI;
              delay_cnt    <= 32'd0;
              state        <= DELAY;
            end else begin
              trig_short <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end else if (trig_s && (width_cnt != WIDTH_MAX)) begin
            width_cnt <= width_cnt + 16'd1;
          end
        end

        DELAY: begin
          if (delay_cnt == DELAY_LAST) begin
            echo_cnt <= 32'd0;
            echo_out <= 1'b1;
            state    <= ECHO;
          end else begin
            delay_cnt <= delay_cnt + 32'd1;
          end
        end

        ECHO: begin
          if (echo_cnt == echo_len - 32'd1) begin
            echo_out <= 1'b0;
            hold_cnt <= 32'd0;
            state    <= HOLDOFF;
          end else begin
            echo_cnt <= echo_cnt + 32'd1;
          end
        end

        HOLDOFF: begin
          if (hold_cnt == HOLD_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        default: begin
          echo_out <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sonar_echo_emu.sv
// Directed bench for sonar_echo_emu with short timing parameters.
`timescale 1ns/1ps
`default_nettype none

module tb_sonar_echo_emu;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       trig_in = 1'b0;
  logic [8:0] distance_in = 9'd12;
  logic       echo_out;
  logic       busy;
  logic       trig_short;
  logic [8:0] dist_latched;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  sonar_echo_emu #(
    .CYCLES_PER_INCH  (10),
    .TRIG_MIN_CYCLES  (5),
    .ECHO_DELAY_CYCLES(3),
    .HOLDOFF_CYCLES   (20),
    .MIN_INCHES       (6),
    .MAX_INCHES       (254)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig_in     (trig_in),
    .distance_in (distance_in),
    .echo_out    (echo_out),
    .busy        (busy),
    .trig_short  (trig_short),
    .dist_latched(dist_latched)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic pulse(input int hi);
    trig_in = 1'b1;
    repeat (hi) step();
    trig_in = 1'b0;
  endtask

  // Called right after trig_in is driven low; echo must rise 5 edges after
  // the first edge sampling the low level.
  task automatic measure(input string tag, input int exp_w);
    int n;
    n = 0;
    while (!echo_out && n < 50) begin step(); n++; end
    check({tag, " delay"}, n - 1, 5);
    n = 0;
    while (echo_out && n < 5000) begin step(); n++; end
    check({tag, " width"}, n, exp_w);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin step(); n++; end
  endtask

  initial begin
    int n;
    int shorts;
    int echoes;
    int t0;
    int d [3] = '{6, 10, 20};

    // reset state
    step(); step();
    check("reset echo", echo_out, 0);
    check("reset busy", busy, 0);
    check("reset trig_short", trig_short, 0);
    check("reset dist", dist_latched, 6);
    rst = 1'b1;
    step(); step();

    // nominal
    distance_in = 9'd12;
    pulse(8);
    check("nom busy", busy, 1);
    measure("nom", 120);
    check("nom dist", dist_latched, 12);
    wait_idle(n);
    check("nom holdoff", n, 20);
    step();

    // short trigger
    shorts = 0; echoes = 0;
    pulse(3);
    repeat (12) begin
      step();
      shorts += int'(trig_short);
      echoes += int'(echo_out);
    end
    check("short pulses", shorts, 1);
    check("short echo", echoes, 0);
    check("short busy", busy, 0);
    check("short dist", dist_latched, 12);

    // clamps
    distance_in = 9'd2;
    pulse(8);
    measure("clamp lo", 60);
    check("clamp lo dist", dist_latched, 6);
    wait_idle(n);
    step();
    distance_in = 9'd300;
    pulse(8);
    measure("clamp hi", 2540);
    check("clamp hi dist", dist_latched, 254);
    wait_idle(n);
    step();

    // retrigger during echo and holdoff, distance changed mid-echo
    distance_in = 9'd12;
    pulse(8);
    fork
      measure("retrig", 120);
      begin
        repeat (30) @(posedge clk);
        #2;
        distance_in = 9'd40;
        trig_in = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        trig_in = 1'b0;
      end
    join
    pulse(8);
    echoes = 0; shorts = 0;
    repeat (80) begin
      step();
      echoes += int'(echo_out);
      shorts += int'(trig_short);
    end
    check("retrig no echo", echoes, 0);
    check("retrig no short", shorts, 0);
    check("retrig dist", dist_latched, 12);
    check("retrig idle", busy, 0);

    // reset mid-echo
    distance_in = 9'd12;
    pulse(8);
    n = 0;
    while (!echo_out && n < 50) begin step(); n++; end
    repeat (50) step();
    check("pre-reset echo", echo_out, 1);
    #3;
    rst = 1'b0;
    #1;
    check("async reset echo", echo_out, 0);
    check("async reset busy", busy, 0);
    step();
    rst = 1'b1;
    step(); step();
    distance_in = 9'd7;
    pulse(8);
    measure("post-reset", 70);
    check("post-reset dist", dist_latched, 7);
    wait_idle(n);

    // back-to-back every 200 cycles
    for (int i = 0; i < 3; i++) begin
      t0 = cyc;
      distance_in = 9'(d[i]);
      pulse(8);
      measure($sformatf("b2b%0d", i), d[i] * 10);
      wait_idle(n);
      while (cyc - t0 < 200) step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
